// File: rtl/pipe_id_issue_pkg.sv
// Shared definitions for the ID issue stage: default widths and the
// operand forward-select encoding used by the forwarding muxes.
package pipe_id_issue_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RA_W   = 5;
  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_MD_LAT = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // EXE has priority over MEM; the callers already exclude r0.
  function automatic fwd_sel_e fwd_select(input logic hit_exe, input logic hit_mem);
    if (hit_exe)      return FWD_EXE;
    else if (hit_mem) return FWD_MEM;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/regfile_2w2r.sv
// Register file with two read and two write ports.
//   clk, rst_n     : clock, asynchronous active-low reset (clears all regs)
//   ra1/ra2 -> rd1/rd2 : read ports; r0 always reads zero
//   we_a/wa_a/wd_a : write port A (WB)
//   we_b/wa_b/wd_b : write port B (mult/div)
// Reads are write-first: a register written this cycle reads the new data.
module regfile_2w2r import pipe_id_issue_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RA_W   = DEF_RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we_a,
  input  logic [RA_W-1:0]   wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [RA_W-1:0]   wa_b,
  input  logic [DATA_W-1:0] wd_b
);

  localparam int unsigned NREG = 1 << RA_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we_a && (wa_a != '0)) regs_d[wa_a] = wd_a;
    if (we_b && (wa_b != '0)) regs_d[wa_b] = wd_b;
  end

  // Reading the next-state array gives the write-first bypass for free.
  assign rd1 = (ra1 == '0) ? '0 : regs_d[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_d[ra2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/pipe_id_issue.sv
// ID issue stage: register file, operand forwarding, hazard detection
// (load-use, mult/div RAW, WAW and structural) and the ID/EXE register.
//   mem_clock, resetn : clock, asynchronous active-low reset
//   id_*              : decoded instruction fields from the control unit
//   exe_alu, mem_*    : forwarding sources from EXE and MEM
//   wb_*, md_*        : register file write ports (WB, mult/div unit)
//   wpcir             : 0 = stall, hold PC and IF/ID
//   id_q1/id_q2       : forwarded operands, rsrtequ their equality
//   ex_*              : ID/EXE pipeline register outputs
//   md_busy           : mult/div operation in flight
module pipe_id_issue import pipe_id_issue_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RA_W   = DEF_RA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned MD_LAT = DEF_MD_LAT
) (
  input  logic              mem_clock,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_md,
  input  logic [RA_W-1:0]   id_wnum,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] exe_alu,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [RA_W-1:0]   mem_wnum,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_mem_out,
  input  logic              wb_wreg,
  input  logic [RA_W-1:0]   wb_wnum,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_wen,
  input  logic [RA_W-1:0]   md_wnum,
  input  logic [DATA_W-1:0] md_wdata,
  output logic              wpcir,
  output logic [DATA_W-1:0] id_q1,
  output logic [DATA_W-1:0] id_q2,
  output logic              rsrtequ,
  output logic              ex_valid,
  output logic              ex_wreg,
  output logic              ex_m2reg,
  output logic              ex_md,
  output logic [RA_W-1:0]   ex_wnum,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_q1,
  output logic [DATA_W-1:0] ex_q2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              md_busy
);

  localparam int unsigned CNT_W = $clog2(MD_LAT + 1);

  logic [DATA_W-1:0] rf_q1, rf_q2, mem_val;
  fwd_sel_e          fwd1, fwd2;
  logic              src_ex_ld, src_md_pend;
  logic              loaduse, mdraw, mdwaw, mdstruct, stall;

  logic              ex_valid_q, ex_valid_d, ex_wreg_q, ex_wreg_d;
  logic              ex_m2reg_q, ex_m2reg_d, ex_md_q, ex_md_d;
  logic [RA_W-1:0]   ex_wnum_q, ex_wnum_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_q1_q, ex_q1_d, ex_q2_q, ex_q2_d, ex_imm_q, ex_imm_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic [RA_W-1:0]   md_pend_q, md_pend_d;

  regfile_2w2r #(.DATA_W(DATA_W), .RA_W(RA_W)) u_rf (
    .clk   (mem_clock),
    .rst_n (resetn),
    .ra1   (id_rs),
    .ra2   (id_rt),
    .rd1   (rf_q1),
    .rd2   (rf_q2),
    .we_a  (wb_wreg),
    .wa_a  (wb_wnum),
    .wd_a  (wb_data),
    .we_b  (md_wen),
    .wa_b  (md_wnum),
    .wd_b  (md_wdata)
  );

  // Forwarding
  always_comb begin
    mem_val = mem_m2reg ? mem_mem_out : mem_alu;
    fwd1 = fwd_select((id_rs != '0) && ex_valid_q && ex_wreg_q && (ex_wnum_q == id_rs),
                      (id_rs != '0) && mem_wreg && (mem_wnum == id_rs));
    fwd2 = fwd_select((id_rt != '0) && ex_valid_q && ex_wreg_q && (ex_wnum_q == id_rt),
                      (id_rt != '0) && mem_wreg && (mem_wnum == id_rt));
    case (fwd1)
      FWD_EXE: id_q1 = exe_alu;
      FWD_MEM: id_q1 = mem_val;
      default: id_q1 = rf_q1;
    endcase
    case (fwd2)
      FWD_EXE: id_q2 = exe_alu;
      FWD_MEM: id_q2 = mem_val;
      default: id_q2 = rf_q2;
    endcase
  end

  assign rsrtequ = (id_q1 == id_q2);

  // Hazards. At counter==1 the MD result is written this cycle and the
  // regfile bypass supplies it, so RAW/WAW only stall while counter>1.
  always_comb begin
    src_ex_ld   = (id_use_rs && (id_rs == ex_wnum_q)) ||
                  (id_use_rt && (id_rt == ex_wnum_q));
    src_md_pend = (id_use_rs && (id_rs == md_pend_q)) ||
                  (id_use_rt && (id_rt == md_pend_q));
    loaduse  = ex_valid_q && ex_m2reg_q && (ex_wnum_q != '0) && src_ex_ld;
    mdraw    = (md_cnt_q > CNT_W'(1)) && (md_pend_q != '0) && src_md_pend;
    mdwaw    = (md_cnt_q > CNT_W'(1)) && id_wreg && (id_wnum == md_pend_q);
    mdstruct = id_md && (md_cnt_q != '0);
    stall    = id_valid && (loaduse || mdraw || mdwaw || mdstruct);
  end

  assign wpcir = ~stall;

  // ID/EXE register next state and mult/div tracking
  always_comb begin
    ex_valid_d = '0;
    ex_wreg_d  = '0;
    ex_m2reg_d = '0;
    ex_md_d    = '0;
    ex_wnum_d  = ex_wnum_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_q1_d    = ex_q1_q;
    ex_q2_d    = ex_q2_q;
    ex_imm_d   = ex_imm_q;
    md_cnt_d   = md_cnt_q;
    md_pend_d  = md_pend_q;
    if (!stall) begin
      ex_valid_d = id_valid;
      ex_wreg_d  = id_wreg  && id_valid;
      ex_m2reg_d = id_m2reg && id_valid;
      ex_md_d    = id_md    && id_valid;
      ex_wnum_d  = id_wnum;
      ex_ctrl_d  = id_ctrl;
      ex_q1_d    = id_q1;
      ex_q2_d    = id_q2;
      ex_imm_d   = id_imm;
    end
    if (!stall && id_valid && id_md) begin
      md_cnt_d  = CNT_W'(MD_LAT);
      md_pend_d = id_wnum;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge mem_clock or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q <= '0;
      ex_wreg_q  <= '0;
      ex_m2reg_q <= '0;
      ex_md_q    <= '0;
      ex_wnum_q  <= '0;
      ex_ctrl_q  <= '0;
      ex_q1_q    <= '0;
      ex_q2_q    <= '0;
      ex_imm_q   <= '0;
      md_cnt_q   <= '0;
      md_pend_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_m2reg_q <= ex_m2reg_d;
      ex_md_q    <= ex_md_d;
      ex_wnum_q  <= ex_wnum_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_q1_q    <= ex_q1_d;
      ex_q2_q    <= ex_q2_d;
      ex_imm_q   <= ex_imm_d;
      md_cnt_q   <= md_cnt_d;
      md_pend_q  <= md_pend_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_wreg  = ex_wreg_q;
  assign ex_m2reg = ex_m2reg_q;
  assign ex_md    = ex_md_q;
  assign ex_wnum  = ex_wnum_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_q1    = ex_q1_q;
  assign ex_q2    = ex_q2_q;
  assign ex_imm   = ex_imm_q;
  assign md_busy  = (md_cnt_q != '0);

endmodule
